// File: rtl/vbuf_pkg.sv
// vbuf_pkg: shared constants for the video buffer SRAM and the scheduler.
//   VBUF_*  : background frame buffer geometry (one RGB444 word per pixel)
//   FISH_*  : sprite image geometry and count, stored after the frame buffer
//   RAM_SIZE: first invalid SRAM address (frame buffer plus all sprite images)
//   sched_state_t: scheduler FSM encoding
package vbuf_pkg;

    localparam int VBUF_W   = 320;
    localparam int VBUF_H   = 240;
    localparam int VBUF_SZ  = VBUF_W * VBUF_H;

    localparam int FISH_W   = 64;
    localparam int FISH_H   = 32;
    localparam int FISH_SZ  = FISH_W * FISH_H;
    localparam int FISH_CNT = 8;

    localparam int RAM_SIZE = VBUF_SZ + FISH_CNT * FISH_SZ;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/vbuf_sram_sched_rd_tag_pipe.sv
// rd_tag_pipe: two-stage shift register carrying read tags {valid, requester
// index} alongside the SRAM access, so returning data is steered to the
// requester that issued it. Data-width agnostic.
//   clk, reset            : clock, asynchronous active-high reset
//   push_valid, push_idx  : tag for the read issued at this edge
//   pop_valid, pop_idx    : tag whose SRAM data is on sram_rdata now
module rd_tag_pipe #(
    parameter int IW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_valid,
    input  logic [IW-1:0] push_idx,
    output logic          pop_valid,
    output logic [IW-1:0] pop_idx
);

    logic [1:0]    vld_q;
    logic [IW-1:0] idx_q [2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q    <= '0;
            idx_q[0] <= '0;
            idx_q[1] <= '0;
        end else begin
            vld_q    <= {vld_q[0], push_valid};
            idx_q[0] <= push_idx;
            idx_q[1] <= idx_q[0];
        end
    end

    assign pop_valid = vld_q[1];
    assign pop_idx   = idx_q[1];

endmodule

// File: rtl/vbuf_sram_sched.sv
// vbuf_sram_sched: slot scheduler sharing the single-port video SRAM between
// NRD pixel-pipeline readers and one writer. pixel_tick opens a window of
// SLOTS cycles; slot k < NRD reads for requester k, the rest (or the whole
// window when blank, or any IDLE cycle) are write opportunities.
//   clk, reset                  : clock, asynchronous active-high reset
//   pixel_tick, blank           : window start pulse, blank window flag
//   rd_addr / rd_data / rd_valid: per-requester packed lanes (k*AW / k*DW)
//   wr_req, wr_addr, wr_data    : write request, held until wr_ack
//   wr_ack, wr_err              : write accepted / dropped (out of range)
//   ovf, ovf_clr                : sticky window overrun flag and its clear
//   sram_*                      : registered SRAM port, 1-cycle read latency
module vbuf_sram_sched #(
    parameter int AW       = 18,
    parameter int DW       = 12,
    parameter int NRD      = 2,
    parameter int SLOTS    = 4,
    parameter int RAM_SIZE = vbuf_pkg::RAM_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pixel_tick,
    input  logic              blank,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_valid,
    input  logic              wr_req,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    input  logic              ovf_clr,
    output logic              ovf,
    output logic              sram_en,
    output logic              sram_we,
    output logic [AW-1:0]     sram_addr,
    output logic [DW-1:0]     sram_wdata,
    input  logic [DW-1:0]     sram_rdata
);

    import vbuf_pkg::*;

    localparam int            SW        = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int            IW        = (NRD > 1) ? $clog2(NRD) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);
    localparam logic [31:0]   RAM_LIM   = 32'(RAM_SIZE);

    sched_state_t  state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic          blank_q, blank_d;
    logic          overrun;

    logic [AW-1:0] rd_addr_arr [NRD];
    logic [DW-1:0] rd_data_q   [NRD];
    logic [IW-1:0] rd_idx;
    logic          is_read;
    logic          wr_take;
    logic          wr_ok;
    logic          pop_valid;
    logic [IW-1:0] pop_idx;

    for (genvar k = 0; k < NRD; k++) begin : g_lane
        assign rd_addr_arr[k]      = rd_addr[k*AW +: AW];
        assign rd_data[k*DW +: DW] = rd_data_q[k];
    end

    // Next window position. A tick always restarts the window; it is an
    // overrun only if the current window had not reached its last slot.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        slot_d  = slot_q;
        blank_d = blank_q;
        overrun = 1'b0;
        if (pixel_tick) begin
            state_d = RUN;
            slot_d  = '0;
            blank_d = blank;
            overrun = (state_q == RUN) && (slot_q != LAST_SLOT);
        end else if (state_q == RUN) begin
            if (slot_q == LAST_SLOT) begin
                state_d = IDLE;
                slot_d  = '0;
            end else begin
                slot_d = slot_q + 1'b1;
            end
        end
    end

    // Issue decisions are made for the slot being entered at this edge, so
    // they look at the next-state values rather than the current ones.
    assign rd_idx  = IW'(slot_d);
    assign is_read = (state_d == RUN) && !blank_d && (32'(slot_d) < 32'(NRD));
    // The !wr_ack term enforces the one-cycle gap the requester needs to
    // present its next address/data after an ack.
    assign wr_take = !is_read && wr_req && !wr_ack;
    assign wr_ok   = 32'(wr_addr) < RAM_LIM;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            blank_q    <= 1'b0;
            ovf        <= 1'b0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            wr_ack     <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            // NOTE: registers use non-blocking assignment so every update in
            // this block sees the pre-edge values of the others.
            state_q <= state_d;
            slot_q  <= slot_d;
            blank_q <= blank_d;

            // Set has priority over clear so a simultaneous overrun is kept.
            if (overrun) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end

            sram_en <= 1'b0;
            sram_we <= 1'b0;
            wr_ack  <= 1'b0;
            wr_err  <= 1'b0;
            if (is_read) begin
                sram_en   <= 1'b1;
                sram_addr <= rd_addr_arr[rd_idx];
            end else if (wr_take) begin
                wr_ack <= 1'b1;
                if (wr_ok) begin
                    sram_en    <= 1'b1;
                    sram_we    <= 1'b1;
                    sram_addr  <= wr_addr;
                    sram_wdata <= wr_data;
                end else begin
                    wr_err <= 1'b1;
                end
            end
        end
    end

    rd_tag_pipe #(
        .IW (IW)
    ) u_rd_tag_pipe (
        .clk        (clk),
        .reset      (reset),
        .push_valid (is_read),
        .push_idx   (rd_idx),
        .pop_valid  (pop_valid),
        .pop_idx    (pop_idx)
    );

    // Returning read data lands in the lane named by its tag; other lanes
    // keep their last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= '0;
            // NOTE: this small per-lane capture bank is reset explicitly
            // because rd_data must read 0 after reset; it is flops, not RAM.
            for (int k = 0; k < NRD; k++) begin
                rd_data_q[k] <= '0;
            end
        end else begin
            rd_valid <= '0;
            if (pop_valid) begin
                rd_valid[pop_idx]  <= 1'b1;
                rd_data_q[pop_idx] <= sram_rdata;
            end
        end
    end

endmodule

// File: doc/vbuf_sram_sched.md
# vbuf_sram_sched

Slot-based scheduler that shares the single-port video SRAM (background frame buffer plus sprite images) between NRD pixel-pipeline read requesters and one write requester (image loader or drawing engine). Each pixel window, opened by `pixel_tick`, is divided into SLOTS clock cycles: slot k < NRD serves read requester k, and the remaining slots serve writes. The block sits between the pixel AGU/compositor and the `sram` instance, and replaces the ad-hoc two-phase address toggle.

## Interface
- AW, 18: SRAM address width.
- DW, 12: SRAM data width (RGB444).
- NRD, 2: number of read requesters (background, sprite); 1 ≤ NRD ≤ SLOTS.
- SLOTS, 4: clk cycles per pixel window (100 MHz clk, 25 MHz pixel).
- RAM_SIZE, 93184: valid address bound (320·240 + 8·64·32).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pixel_tick  in  1  one-cycle pulse that opens a pixel window.
- blank  in  1  sampled with pixel_tick; 1 = the whole window is write slots.
- rd_addr  in  NRD*AW  per-requester read address; requester k uses bits [k*AW +: AW].
- rd_data  out  NRD*DW  per-requester captured read data; held until overwritten.
- rd_valid  out  NRD  one-cycle pulse: rd_data[k] updated.
- wr_req  in  1  write request; held until acked.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- wr_ack  out  1  one-cycle pulse: write accepted (issued or dropped).
- wr_err  out  1  one-cycle pulse with wr_ack when wr_addr ≥ RAM_SIZE (write dropped).
- ovf_clr  in  1  clears ovf.
- ovf  out  1  sticky: pixel_tick arrived before the window completed.
- sram_en, sram_we  out  1  SRAM controls (registered).
- sram_addr  out  AW  registered SRAM address.
- sram_wdata  out  DW  registered SRAM write data.
- sram_rdata  in  DW  SRAM output; valid one clk after the address is captured.

## Operation
- FSM has two states, IDLE and RUN, plus a slot counter `slot` (0..SLOTS-1).
- On reset: IDLE, slot=0, all outputs 0 (sram_addr/wdata=0, en/we=0, rd_data=0, rd_valid=0, wr_ack=0, wr_err=0, ovf=0), read pipeline tags cleared.
- pixel_tick in any state → RUN, slot=0, window_blank ← blank. If the state is RUN and slot ≠ SLOTS-1 at that edge, ovf ← 1.
- RUN: slot increments each cycle. After slot SLOTS-1 with no tick → IDLE.
- Slot issue, registered at the edge that enters the slot:
  - Read slot (slot < NRD and !window_blank): sram_en=1, we=0, sram_addr ← rd_addr[slot], and a tag {valid, slot} is pushed.
  - Write slot (slot ≥ NRD, blank window, or IDLE state) with wr_req=1 and wr_ack not asserted in the previous cycle: wr_ack pulses. If wr_addr < RAM_SIZE, drive en=1, we=1, addr/wdata; otherwise en=0 and wr_err=1.
  - Otherwise: en=0, we=0, and addr holds its value.
- Tag pipeline is two deep. A tag issued at edge E makes rd_data[k] ← sram_rdata at E+2, and rd_valid[k]=1 for the cycle after E+2. Other rd_data lanes are unchanged.
- In-flight reads complete across a new pixel_tick or an overrun. Reset discards them with no rd_valid.
- ovf_clr clears ovf; if ovf_clr and an overrun occur together, set wins.
- Address arithmetic is unsigned AW bits. Requesters supply final addresses; no offset math happens here.

## Timing
- Read latency: address sampled at the slot-entry edge; data plus rd_valid 2 clk later. Every read lane has fixed phase within the window.
- Write: wr_ack coincides with the cycle sram_we=1. The requester changes addr/data or drops req on the cycle after ack. At most one write per 2 clk (ack gap).
- Back-to-back ticks exactly SLOTS apart: RUN continuous, never IDLE, ovf stays 0.
- A tick with blank=1 gives SLOTS write opportunities (⌈SLOTS/2⌉ accepted max).

## Structure
- Shared package `vbuf_pkg`: VBUF_W=320, VBUF_H=240, VBUF_SZ, FISH_W/H/SZ/CNT, RAM_SIZE, and the state encoding {IDLE, RUN}.
- Single module. The 2-deep read-tag shift register may be factored as `rd_tag_pipe` (DW-agnostic: valid plus log2(NRD) index).

## Test plan
- Reset, ticks every 4 clk, NRD=2, rd_addr={100,76800}, SRAM model preloaded → rd_valid[0] 2 clk after slot 0 with mem[100], rd_valid[1] one clk later with mem[76800], ovf=0.
- wr_req held, addr=5, data=0xABC, ticks every 4 clk, blank=0 → ack only in slots 2/3 with we=1; following read of addr 5 returns 0xABC.
- blank=1 window, wr_req held with changing data → no read issued, acks at slots 0 and 2, none adjacent.
- wr_addr=93184 → wr_ack and wr_err same cycle, sram_we stays 0, memory unchanged.
- Tick after only 2 clk → ovf=1 and stays 1; slot-0 read still returns data; ovf_clr → 0.
- Reset asserted one clk after a read issue → no rd_valid, all outputs 0 asynchronously; next tick resumes normally.
